// File: rtl/prime_div3_enumerator.sv
// Enumerates, in ascending order, every WIDTH-bit value whose {prime, div-by-3} class matches a requested class.
// Latency: start -> first candidate examined next cycle; a non-match costs 1 cycle, an emitted match at least 2 (SCAN + HOLD).
// Backpressure: a match is held on out_valid/out_num until out_ready; the scan does not advance while held.
module prime_div3_enumerator #(
    parameter int WIDTH = 4    // even, 4..8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       care,
    input  logic [1:0]       tgt,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_num,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   match_count
);

    // Trial divisors only need to reach sqrt(2^WIDTH - 1), i.e. below 2^(WIDTH/2).
    localparam int KMAX = 2 ** (WIDTH / 2);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] cnt;
    logic [1:0]       care_q;
    logic [1:0]       tgt_q;

    // Control strobes shared by the counter and every residue register.
    logic             clr_res;    // scan accepted: restart counter and residues at 0
    logic             adv;        // step cnt and all residues by one
    logic             last;       // current candidate is the top of the range
    logic             accept;     // handshake completes this cycle

    // Classification of the current candidate.
    logic [KMAX:2]    factor_hit; // divisor k divides cnt and k*k <= cnt
    logic             is_p;
    logic             is_d;
    logic             is_match;

    // One residue register per trial divisor. Each tracks cnt mod k by
    // stepping and wrapping in lockstep with cnt, so no divider is needed.
    for (genvar g = 2; g <= KMAX; g++) begin : g_res
        localparam logic [7:0]  RTOP = 8'(g - 1);
        localparam logic [31:0] SQ   = 32'(g * g);

        logic [7:0] r;

        // Residue of cnt modulo g, cleared when a scan starts.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r <= 8'd0;
            end else if (clr_res) begin
                r <= 8'd0;
            end else if (adv) begin
                r <= (r == RTOP) ? 8'd0 : r + 8'd1;
            end
        end

        // A divisor only disqualifies primality when it is a proper factor
        // candidate (k*k <= n); this keeps small primes like 2 and 3 prime.
        assign factor_hit[g] = (r == 8'd0) && (SQ <= 32'(cnt));
    end

    // Classify the current candidate and derive the step/clear strobes.
    always_comb begin
        last     = (cnt == CNT_MAX);
        is_p     = (cnt[WIDTH-1:1] != '0) && (factor_hit == '0);
        is_d     = (cnt != '0) && (g_res[3].r == 8'd0);
        is_match = (!care_q[1] || (is_p == tgt_q[1])) &&
                   (!care_q[0] || (is_d == tgt_q[0]));
        clr_res  = (state == S_IDLE) && start;
        accept   = (state == S_HOLD) && out_ready;
        adv      = !last && (((state == S_SCAN) && !is_match) || accept);
    end

    // Next-state selection for the scan sequencer.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (is_match) begin
                    next_state = S_HOLD;
                end else if (last) begin
                    next_state = S_DONE;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    next_state = last ? S_DONE : S_SCAN;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Candidate counter; never wraps because the top value ends the scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr_res) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Requested class is captured once per scan so mid-scan input changes are harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            care_q <= 2'b00;
            tgt_q  <= 2'b00;
        end else if (clr_res) begin
            care_q <= care;
            tgt_q  <= tgt;
        end
    end

    // Output register: load a match in SCAN, hold it until the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_num   <= '0;
        end else if ((state == S_SCAN) && is_match) begin
            out_valid <= 1'b1;
            out_num   <= cnt;
        end else if (accept) begin
            out_valid <= 1'b0;
        end
    end

    // Match counter: cleared on an accepted start, held after the scan ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_count <= '0;
        end else if (clr_res) begin
            match_count <= '0;
        end else if ((state == S_SCAN) && is_match) begin
            match_count <= match_count + 1'b1;
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_prime_div3_enumerator.sv
// Bench for prime_div3_enumerator at WIDTH=4 and WIDTH=6.
// Table vectors plus randomized scans, checked against a trial-division reference model.
// Consumer ready is randomized per cycle; optional stall and mid-scan start pokes.
module tb_prime_div3_enumerator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, start6, out_ready;
    logic [1:0] care, tgt;

    logic       ov4, busy4, done4;
    logic [3:0] num4;
    logic [4:0] mc4;
    logic       ov6, busy6, done6;
    logic [5:0] num6;
    logic [6:0] mc6;

    int n_cmp = 0;
    int n_bad = 0;

    prime_div3_enumerator #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(rst), .start(start4), .care(care), .tgt(tgt),
        .out_ready(out_ready), .out_valid(ov4), .out_num(num4),
        .busy(busy4), .done(done4), .match_count(mc4)
    );

    prime_div3_enumerator #(.WIDTH(6)) dut6 (
        .clk(clk), .reset(rst), .start(start6), .care(care), .tgt(tgt),
        .out_ready(out_ready), .out_valid(ov6), .out_num(num6),
        .busy(busy6), .done(done6), .match_count(mc6)
    );

    typedef struct {
        bit         w6;
        logic [1:0] c;
        logic [1:0] t;
        int         rpct;      // percent chance ready is high each cycle
        int         stall_at;  // hold ready low 5 cycles when this value is offered (-1 off)
        bit         poke;      // pulse start mid-scan with a different class
        int         exp_n;     // -1: take from model
        int         exp_last;  // -1: take from model
        int         first_lat; // -1: unchecked
        int         done_lat;  // -1: unchecked
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference classifier: plain trial division over every smaller divisor.
    function automatic bit m_prime(input int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k < n; k++) begin
            if (n % k == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit m_match(input int n, input logic [1:0] c, input logic [1:0] t);
        bit p;
        bit d;
        p = m_prime(n);
        d = (n != 0) && (n % 3 == 0);
        return (!c[1] || (p == t[1])) && (!c[0] || (d == t[0]));
    endfunction

    task automatic scan(input vec_t v, input string nm);
        int  exp_q[$];
        int  w, got_n, got_last, first_lat, done_lat, stall_left, prev_num, num, mc, en, el;
        bit  prev_ov, prev_acc, ov, dn, bz, rdy;
        w = v.w6 ? 6 : 4;
        for (int n = 0; n < (1 << w); n++) begin
            if (m_match(n, v.c, v.t)) exp_q.push_back(n);
        end
        en = (v.exp_n < 0) ? exp_q.size() : v.exp_n;
        el = (v.exp_last < 0) ? ((exp_q.size() > 0) ? exp_q[$] : -1) : v.exp_last;
        got_n = 0; got_last = -1; first_lat = -1; done_lat = -1;
        stall_left = 5; prev_ov = 0; prev_acc = 0; prev_num = 0;

        @(negedge clk);
        care = v.c; tgt = v.t; out_ready = 1'b0;
        if (v.w6) start6 = 1'b1; else start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; start6 = 1'b0;

        for (int cyc = 1; cyc < 5000; cyc++) begin
            ov  = v.w6 ? ov6 : ov4;
            num = v.w6 ? int'(num6) : int'(num4);
            dn  = v.w6 ? done6 : done4;
            bz  = v.w6 ? busy6 : busy4;
            if (prev_ov && !prev_acc) begin
                chk({nm, " hold_valid"}, int'(ov), 1);
                chk({nm, " hold_num"}, num, prev_num);
            end
            if (ov && first_lat < 0) first_lat = cyc;
            if (dn) begin
                done_lat = cyc;
                chk({nm, " busy_in_done"}, int'(bz), 1);
                break;
            end
            rdy = ($urandom_range(0, 99) < v.rpct);
            if (ov && num == v.stall_at && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end
            out_ready = rdy;
            if (v.poke && cyc == 5) begin
                care = ~v.c; tgt = ~v.t;
                if (v.w6) start6 = 1'b1; else start4 = 1'b1;
            end else begin
                start4 = 1'b0; start6 = 1'b0;
            end
            if (ov && rdy) begin
                got_n++;
                got_last = num;
                if (exp_q.size() == 0) chk({nm, " extra_emit"}, num, -1);
                else chk({nm, " emit"}, num, exp_q.pop_front());
            end
            prev_ov = ov; prev_acc = ov && rdy; prev_num = num;
            @(negedge clk);
        end
        start4 = 1'b0; start6 = 1'b0; out_ready = 1'b0;

        if (done_lat < 0) chk({nm, " timeout_no_done"}, 0, 1);
        mc = v.w6 ? int'(mc6) : int'(mc4);
        chk({nm, " match_count"}, mc, en);
        chk({nm, " emitted_n"}, got_n, en);
        chk({nm, " last_emit"}, got_last, el);
        chk({nm, " missing"}, exp_q.size(), 0);
        if (v.first_lat >= 0) chk({nm, " first_valid_lat"}, first_lat, v.first_lat);
        if (v.done_lat >= 0) chk({nm, " done_lat"}, done_lat, v.done_lat);
        if (v.stall_at >= 0) chk({nm, " stall_done"}, stall_left, 0);

        @(negedge clk);
        chk({nm, " done_one_cycle"}, int'(v.w6 ? done6 : done4), 0);
        chk({nm, " idle_after"}, int'(v.w6 ? busy6 : busy4), 0);
        chk({nm, " mc_held"}, v.w6 ? int'(mc6) : int'(mc4), en);
    endtask

    initial begin
        vec_t rv;
        int   waited;

        tbl[0] = '{1'b0, 2'b11, 2'b10, 100, -1, 1'b0,  5, 13, -1, -1};
        tbl[1] = '{1'b0, 2'b11, 2'b01, 100, -1, 1'b0,  4, 15, -1, -1};
        tbl[2] = '{1'b0, 2'b11, 2'b11, 100, -1, 1'b0,  1,  3, -1, -1};
        tbl[3] = '{1'b0, 2'b11, 2'b00, 100, -1, 1'b0,  6, 14, -1, -1};
        tbl[4] = '{1'b0, 2'b00, 2'b00, 100, -1, 1'b0, 16, 15,  2, 33};
        tbl[5] = '{1'b0, 2'b10, 2'b10, 100,  5, 1'b0,  6, 13, -1, -1};
        tbl[6] = '{1'b0, 2'b00, 2'b00,  60, -1, 1'b1, 16, 15, -1, -1};
        tbl[7] = '{1'b1, 2'b10, 2'b10, 100, -1, 1'b0, 18, 61, -1, -1};
        tbl[8] = '{1'b0, 2'b01, 2'b01,  50, -1, 1'b0,  5, 15, -1, -1};

        rst = 1'b0; start4 = 1'b0; start6 = 1'b0; out_ready = 1'b0;
        care = 2'b00; tgt = 2'b00;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset out_valid", int'(ov4), 0);
        chk("reset out_num", int'(num4), 0);
        chk("reset busy", int'(busy4), 0);
        chk("reset done", int'(done4), 0);
        chk("reset match_count", int'(mc4), 0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            scan(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset while a match is being offered: everything clears at once.
        @(negedge clk);
        care = 2'b00; tgt = 2'b00; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; out_ready = 1'b0;
        waited = 0;
        while (!ov4 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_mid pre_valid", int'(ov4), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid out_valid", int'(ov4), 0);
        chk("rst_mid out_num", int'(num4), 0);
        chk("rst_mid busy", int'(busy4), 0);
        chk("rst_mid done", int'(done4), 0);
        chk("rst_mid match_count", int'(mc4), 0);
        @(negedge clk);
        rst = 1'b0;
        scan(tbl[3], "rescan");

        // Randomized classes, widths, ready patterns and ignored starts.
        for (int i = 0; i < 16; i++) begin
            rv.w6        = 1'($urandom_range(0, 1));
            rv.c         = 2'($urandom_range(0, 3));
            rv.t         = 2'($urandom_range(0, 3));
            rv.rpct      = $urandom_range(25, 100);
            rv.stall_at  = -1;
            rv.poke      = 1'($urandom_range(0, 1));
            rv.exp_n     = -1;
            rv.exp_last  = -1;
            rv.first_lat = -1;
            rv.done_lat  = -1;
            scan(rv, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
